hex_counter_disp: RTL and testbench
===================================

// Module: hex_counter_disp
// PURPOSE
//   Clocked, parametrised binary counter with a multi-digit hex display on
//   active-low 7-seg outputs (board switch/LED/7-seg top level).
//   Runs from a prescaled tick, steps manually from a button, counts up or down,
//   loads a value from the switches, and flags terminal count.
// PARAMETERS
//   WIDTH     16        count register width in bits (1..32)
//   DIGITS    4         7-seg digits driven; elaboration error if DIGITS < ceil(WIDTH/4)
//   LEDS      10        LED outputs; l mirrors count[LEDS-1:0], zero-extended if WIDTH<LEDS
//   TICK_DIV  50000000  clk cycles per auto-count tick (>=2)
//   SATURATE  0         0 = wrap at the limits, 1 = hold at the limits
// PORTS
//   clk     in   1          system clock, all state on rising edge
//   rst     in   1          asynchronous, active-high reset
//   en      in   1          switch: 1 = auto-count on tick, 0 = manual step mode
//   up      in   1          switch: 1 = count up, 0 = count down
//   load    in   1          button: rising edge loads ld_val
//   step    in   1          button: rising edge advances by one (only while en=0)
//   ld_val  in   WIDTH      switches: load value
//   d       out  DIGITS*7   7-seg, active low; d[7k+6:7k] = hex nibble k (k=0 is LSN)
//   l       out  LEDS       LEDs: count[LEDS-1:0]
//   tc      out  1          terminal-count pulse, one clk wide
// BEHAVIOUR
//   - Reset (async): count=0, prescaler=0, all sync/edge flops=0, tc=0, l=0,
//     every digit = 7'b1000000 ("0").
//   - en, up, load, step, ld_val pass through 2-flop synchronisers; load/step go on
//     to a third flop for rising-edge detect. Count updates on the 3rd rising clk
//     edge after a load/step input rises. en/up take effect 2 cycles after change.
//   - Prescaler: counts 0..TICK_DIV-1 while en_s=1; tick = (pre==TICK_DIV-1), then wraps
//     to 0. Held at 0 while en_s=0 and on a load; first tick TICK_DIV cycles after enable.
//   - Advance = (en_s & tick) | (~en_s & step_rise). step is ignored while en_s=1.
//   - Priority per cycle: load_rise > advance. Load sets count=ld_val_s, tc stays 0.
//     load held high loads once only.
//   - Up advance: count+1. At 2^WIDTH-1: wrap to 0 (SATURATE=0) or hold (SATURATE=1).
//     Down advance: count-1. At 0: wrap to 2^WIDTH-1 or hold.
//     Arithmetic is modulo 2^WIDTH.
//   - tc = 1 for the cycle after any advance attempted from the limit value (wrap or
//     blocked hold), else 0.
//   - Display: registered decode, d and l valid 1 cycle after count changes.
//     Patterns 0-F: 1000000 1111001 0100100 0110000 0011001 0010010 0000010
//     1111000 0000000 0011000 0001000 0000011 1000110 0100001 0000100 0001110.
//     Top partial nibble and digits above WIDTH are zero-extended.
//   - up change mid-count: direction switches at the next advance; prescaler
//     is not disturbed.
// CONFIGURATION
//   LEADING_ZERO_BLANK_EN defined: digits above the most-significant nonzero
//     nibble show OFF (7'b1111111); digit 0 is never blanked (count 0 -> "0").
//   Not defined: all DIGITS always shown, leading zeros as "0".
// TESTING  (WIDTH=8, DIGITS=2, LEDS=10, TICK_DIV=4 unless stated)
//   1 rst pulse mid-count at 0x37 -> asynchronously count=0,
//     d=14'b1000000_1000000, l=0, tc=0.
//   2 en=1,up=1 from 0 for 1030 clk -> +1 every 4 clk; at 0xFF d=0001110_0001110;
//     next tick count=0x00, single-cycle tc.
//   3 en=1,up=0 from 0x00 -> next tick count=0xFF, tc pulse; then 0xFE.
//   4 ld_val=0xA5, load rises -> count=0xA5 on 3rd edge, d=0001000_0010010
//     one cycle later; load held 20 clk -> no reload; load and tick coincident -> 0xA5.
//   5 en=0, three step pulses from 0x10 -> 0x13, no auto ticks;
//     en=1 with step pulses -> steps ignored.
//   6 SATURATE=1, count 0xFF, up, tick -> holds 0xFF, tc pulse;
//     with LEADING_ZERO_BLANK_EN, count 0x05 -> d=1111111_0010010.

Source files
------------

// File: rtl/hex_counter_disp.sv
// hex_counter_disp: counter with a multi-digit hex display for a switch/button/LED/7-seg board.
// It counts from a prescaled tick, or steps one at a time from a button.
// It can count up or down, loads a value from the switches, and pulses tc when
// an advance is attempted from a limit value.
// Build option: define LEADING_ZERO_BLANK_EN to turn off the 7-seg digits above the
// most-significant nonzero nibble. Digit 0 always stays lit.

module hex_counter_disp #(
    parameter int WIDTH    = 16,
    parameter int DIGITS   = 4,
    parameter int LEDS     = 10,
    parameter int TICK_DIV = 50000000,
    parameter int SATURATE = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  up,
    input  logic                  load,
    input  logic                  step,
    input  logic [WIDTH-1:0]      ld_val,
    output logic [DIGITS*7-1:0]   d,
    output logic [LEDS-1:0]       l,
    output logic                  tc
);

    localparam int NIBBLES = (WIDTH + 3) / 4;
    localparam int DW      = DIGITS * 4;
    localparam int EXTW    = (LEDS > DW) ? LEDS : DW;
    localparam int PW      = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

    localparam logic [PW-1:0]    PRE_MAX = PW'(TICK_DIV - 1);
    localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);
    localparam logic [WIDTH-1:0] CNT_MAX = '1;
    localparam logic [6:0]       SEG_OFF = 7'b1111111;
    localparam logic [6:0]       SEG_0   = 7'b1000000;

    // Reject parameter combinations the display or prescaler cannot support.
    if (DIGITS < NIBBLES) begin : g_bad_digits
        $error("hex_counter_disp: DIGITS must be at least ceil(WIDTH/4)");
    end
    if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
        $error("hex_counter_disp: WIDTH must be in 1..32");
    end
    if (TICK_DIV < 2) begin : g_bad_div
        $error("hex_counter_disp: TICK_DIV must be at least 2");
    end

    logic             en_s1, en_s;
    logic             up_s1, up_s;
    logic             ld_s1, ld_s2, ld_s3;
    logic             st_s1, st_s2, st_s3;
    logic [WIDTH-1:0] ldv_s1, ldv_s;

    logic             load_rise, step_rise;
    logic [PW-1:0]    pre;
    logic             tick;
    logic             advance;
    logic             at_limit;

    logic [WIDTH-1:0] count, count_next;
    logic             tc_next;

    logic [EXTW-1:0]     ext;
    logic [DIGITS*7-1:0] d_next;
    logic [LEDS-1:0]     l_next;
    logic                seen_nonzero;
    logic [3:0]          nib;

    function automatic logic [6:0] seg7(input logic [3:0] n);
        case (n)
            4'h0:    seg7 = 7'b1000000;
            4'h1:    seg7 = 7'b1111001;
            4'h2:    seg7 = 7'b0100100;
            4'h3:    seg7 = 7'b0110000;
            4'h4:    seg7 = 7'b0011001;
            4'h5:    seg7 = 7'b0010010;
            4'h6:    seg7 = 7'b0000010;
            4'h7:    seg7 = 7'b1111000;
            4'h8:    seg7 = 7'b0000000;
            4'h9:    seg7 = 7'b0011000;
            4'hA:    seg7 = 7'b0001000;
            4'hB:    seg7 = 7'b0000011;
            4'hC:    seg7 = 7'b1000110;
            4'hD:    seg7 = 7'b0100001;
            4'hE:    seg7 = 7'b0000100;
            default: seg7 = 7'b0001110;
        endcase
    endfunction

    // Bring the switch and button inputs into the clk domain. The buttons also get
    // a third flop so that their rising edge can be detected.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_s1  <= 1'b0;
            en_s   <= 1'b0;
            up_s1  <= 1'b0;
            up_s   <= 1'b0;
            ld_s1  <= 1'b0;
            ld_s2  <= 1'b0;
            ld_s3  <= 1'b0;
            st_s1  <= 1'b0;
            st_s2  <= 1'b0;
            st_s3  <= 1'b0;
            ldv_s1 <= '0;
            ldv_s  <= '0;
        end else begin
            en_s1  <= en;
            en_s   <= en_s1;
            up_s1  <= up;
            up_s   <= up_s1;
            ld_s1  <= load;
            ld_s2  <= ld_s1;
            ld_s3  <= ld_s2;
            st_s1  <= step;
            st_s2  <= st_s1;
            st_s3  <= st_s2;
            ldv_s1 <= ld_val;
            ldv_s  <= ldv_s1;
        end
    end

    assign load_rise = ld_s2 & ~ld_s3;
    assign step_rise = st_s2 & ~st_s3;
    assign tick      = en_s & (pre == PRE_MAX);
    assign advance   = (en_s & tick) | (~en_s & step_rise);
    assign at_limit  = up_s ? (count == CNT_MAX) : (count == '0);

    // Prescaler. It is held at 0 while the counter is in manual mode, and it
    // restarts on a load so that a full period follows a loaded value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre <= '0;
        end else if (!en_s || load_rise || tick) begin
            pre <= '0;
        end else begin
            pre <= pre + 1'b1;
        end
    end

    // Next count. A load takes priority over an advance. At a limit, the counter
    // either wraps or holds, but tc fires in both cases.
    always_comb begin
        count_next = count;
        tc_next    = 1'b0;
        if (load_rise) begin
            count_next = ldv_s;
        end else if (advance) begin
            tc_next = at_limit;
            if (!(at_limit && SATURATE != 0)) begin
                if (up_s) begin
                    count_next = count + CNT_ONE;
                end else begin
                    count_next = count - CNT_ONE;
                end
            end
        end
    end

    // Count register and terminal-count pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
            tc    <= 1'b0;
        end else begin
            count <= count_next;
            tc    <= tc_next;
        end
    end

    // Zero-extend the count so that the top partial nibble, the unused digits and
    // the spare LEDs all read as zero.
    always_comb begin
        ext              = '0;
        ext[WIDTH-1:0]   = count;
        l_next           = ext[LEDS-1:0];
    end

    // Decode each nibble. The loop scans from the top digit down, so it knows
    // whether a nonzero nibble has already appeared above the current digit.
    always_comb begin
        d_next       = '0;
        seen_nonzero = 1'b0;
        nib          = 4'h0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            nib = ext[4*k +: 4];
`ifdef LEADING_ZERO_BLANK_EN
            if (nib != 4'h0 || k == 0) begin
                seen_nonzero = 1'b1;
            end
            d_next[7*k +: 7] = seen_nonzero ? seg7(nib) : SEG_OFF;
`else
            d_next[7*k +: 7] = seg7(nib);
`endif
        end
    end

    // Register the display and LED outputs. They follow the count one cycle later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d <= {DIGITS{SEG_0}};
            l <= '0;
        end else begin
            d <= d_next;
            l <= l_next;
        end
    end

endmodule

// File: tb/tb_hex_counter_disp.sv
// Self-checking bench for hex_counter_disp (WIDTH=8, DIGITS=2, LEDS=10, TICK_DIV=4).
// A wrapping instance and a saturating instance share the same stimulus.
// Honours LEADING_ZERO_BLANK_EN in its display expectations.

module tb_hex_counter_disp;

    logic        clk = 1'b0;
    logic        rst;
    logic        en, up, load, step;
    logic [7:0]  ld_val;
    logic [13:0] d, d_s;
    logic [9:0]  l, l_s;
    logic        tc, tc_s;

    int vectors     = 0;
    int miscompares = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    hex_counter_disp #(.WIDTH(8), .DIGITS(2), .LEDS(10), .TICK_DIV(4), .SATURATE(0)) dut (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .step(step),
        .ld_val(ld_val), .d(d), .l(l), .tc(tc)
    );

    hex_counter_disp #(.WIDTH(8), .DIGITS(2), .LEDS(10), .TICK_DIV(4), .SATURATE(1)) dut_sat (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .step(step),
        .ld_val(ld_val), .d(d_s), .l(l_s), .tc(tc_s)
    );

    function automatic logic [6:0] seg(input logic [3:0] n);
        case (n)
            4'h0: return 7'b1000000;  4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;  4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;  4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;  4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;  4'h9: return 7'b0011000;
            4'hA: return 7'b0001000;  4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;  4'hD: return 7'b0100001;
            4'hE: return 7'b0000100;  default: return 7'b0001110;
        endcase
    endfunction

    function automatic logic [13:0] disp(input logic [7:0] v);
`ifdef LEADING_ZERO_BLANK_EN
        return {(v[7:4] == 4'h0) ? 7'b1111111 : seg(v[7:4]), seg(v[3:0])};
`else
        return {seg(v[7:4]), seg(v[3:0])};
`endif
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Loads v. The caller must already have en low and settled.
    task automatic do_load(input logic [7:0] v);
        @(negedge clk);
        ld_val = v;
        load   = 1'b1;
        cyc(4);
        load = 1'b0;
        cyc(2);
    endtask

    // Waits for l to change, within a cycle budget. Reports how long the wait took,
    // the value tc had one sample before the change, and how many samples had tc high.
    task automatic wait_l_change(input int budget, output bit ok, output int waited,
                                 output bit tc_before, output int tc_hi);
        logic [9:0] prev;
        bit         prev_tc;
        prev      = l;
        prev_tc   = tc;
        ok        = 1'b0;
        waited    = 0;
        tc_before = 1'b0;
        tc_hi     = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            waited++;
            if (l !== prev) begin
                ok        = 1'b1;
                tc_before = prev_tc;
                return;
            end
            if (tc === 1'b1) tc_hi++;
            prev_tc = tc;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; step = 1'b0; ld_val = 8'h00;
        cyc(3);
        vectors++;
        if (l !== 10'h000) begin miscompares++; $display("FAIL reset_l: got %h want 000", l); end
        vectors++;
        if (d !== 14'b1000000_1000000) begin miscompares++; $display("FAIL reset_d: got %b want 10000001000000", d); end
        vectors++;
        if (tc !== 1'b0) begin miscompares++; $display("FAIL reset_tc: got %b want 0", tc); end
        rst = 1'b0;
        cyc(10);
        vectors++;
        if (l !== 10'h000) begin miscompares++; $display("FAIL idle_after_reset: got %h want 000", l); end
    endtask

    task automatic test_load();
        logic [7:0] e;
        @(negedge clk);
        ld_val = 8'hA5;
        load   = 1'b1;
        exp_q.push_back(8'hA5);
        cyc(3);
        vectors++;
        if (l !== 10'h000) begin miscompares++; $display("FAIL load_latency_early: got %h want 000", l); end
        cyc(1);
        e = exp_q.pop_front();
        vectors++;
        if (l !== {2'b00, e}) begin miscompares++; $display("FAIL load_value: got %h want %h", l, e); end
        vectors++;
        if (d !== 14'b0001000_0010010) begin miscompares++; $display("FAIL load_disp_A5: got %b want 00010000010010", d); end
        ld_val = 8'h3C;
        cyc(20);
        vectors++;
        if (l !== 10'h0A5) begin miscompares++; $display("FAIL load_held_once: got %h want 0a5", l); end
        load = 1'b0;
        cyc(2);

        do_load(8'h05);
        vectors++;
        if (d !== disp(8'h05)) begin miscompares++; $display("FAIL disp_05: got %b want %b", d, disp(8'h05)); end

        do_load(8'hA5);
        up = 1'b1;
        @(negedge clk);
        en = 1'b1;
        cyc(3);
        load = 1'b1;
        cyc(4);
        vectors++;
        if (l !== 10'h0A5) begin miscompares++; $display("FAIL load_beats_tick: got %h want 0a5", l); end
        load = 1'b0;
        cyc(3);
        vectors++;
        if (l !== 10'h0A5) begin miscompares++; $display("FAIL pre_restart_early: got %h want 0a5", l); end
        cyc(1);
        vectors++;
        if (l !== 10'h0A6) begin miscompares++; $display("FAIL pre_restart_tick: got %h want 0a6", l); end
        en = 1'b0;
        cyc(4);
    endtask

    task automatic test_step();
        bit ok, tcb;
        int w, th;
        logic [7:0] e;
        do_load(8'h10);
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h12);
        exp_q.push_back(8'h13);
        for (int p = 0; p < 3; p++) begin
            @(negedge clk);
            step = 1'b1;
            cyc(2);
            step = 1'b0;
            wait_l_change(8, ok, w, tcb, th);
            e = exp_q.pop_front();
            vectors++;
            if (!ok) begin miscompares++; $display("FAIL step_timeout: got no change want %h", e); end
            else if (l !== {2'b00, e}) begin miscompares++; $display("FAIL step_value: got %h want %h", l, e); end
            cyc(1);
        end
        cyc(20);
        vectors++;
        if (l !== 10'h013) begin miscompares++; $display("FAIL manual_no_tick: got %h want 013", l); end

        @(negedge clk);
        en   = 1'b1;
        step = 1'b1;
        cyc(2);
        step = 1'b0;
        cyc(1);
        step = 1'b1;
        cyc(1);
        step = 1'b0;
        cyc(1);
        vectors++;
        if (l !== 10'h013) begin miscompares++; $display("FAIL step_ignored_en: got %h want 013", l); end
        cyc(2);
        vectors++;
        if (l !== 10'h014) begin miscompares++; $display("FAIL tick_with_step: got %h want 014", l); end
        en = 1'b0;
        cyc(4);
    endtask

    task automatic test_count_up();
        bit ok, tcb;
        int w, th, tc_total;
        logic [7:0] e;
        do_load(8'h00);
        up = 1'b1;
        for (int v = 1; v <= 256; v++) exp_q.push_back(8'(v));
        tc_total = 0;
        @(negedge clk);
        en = 1'b1;
        for (int i = 0; i < 256; i++) begin
            wait_l_change(10, ok, w, tcb, th);
            tc_total += th;
            e = exp_q.pop_front();
            vectors++;
            if (!ok) begin
                miscompares++;
                $display("FAIL up_timeout: got no change want %h", e);
                break;
            end
            if (l !== {2'b00, e}) begin miscompares++; $display("FAIL up_value: got %h want %h", l, e); end
            if (d !== disp(e)) begin miscompares++; $display("FAIL up_disp: got %b want %b", d, disp(e)); end
            if (tcb !== (e == 8'h00)) begin miscompares++; $display("FAIL up_tc: got %b want %b at %h", tcb, (e == 8'h00), e); end
            if (i > 0 && w != 4) begin miscompares++; $display("FAIL up_period: got %0d want 4", w); end
            if (e == 8'hFF && d !== 14'b0001110_0001110) begin
                miscompares++;
                $display("FAIL disp_FF: got %b want 00011100001110", d);
            end
        end
        exp_q.delete();
        vectors++;
        if (tc_total != 1) begin miscompares++; $display("FAIL up_tc_width: got %0d want 1", tc_total); end
        en = 1'b0;
        cyc(4);
    endtask

    task automatic test_count_down();
        bit ok, tcb;
        int w, th;
        logic [7:0] e;
        logic       tc_exp[$];
        up = 1'b0;
        do_load(8'h00);
        exp_q.push_back(8'hFF); tc_exp.push_back(1'b1);
        exp_q.push_back(8'hFE); tc_exp.push_back(1'b0);
        exp_q.push_back(8'hFF); tc_exp.push_back(1'b0);
        exp_q.push_back(8'h00); tc_exp.push_back(1'b1);
        @(negedge clk);
        en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wait_l_change(10, ok, w, tcb, th);
            e = exp_q.pop_front();
            vectors++;
            if (!ok) begin miscompares++; $display("FAIL down_timeout: got no change want %h", e); end
            else begin
                if (l !== {2'b00, e}) begin miscompares++; $display("FAIL down_value: got %h want %h", l, e); end
                if (tcb !== tc_exp[i]) begin miscompares++; $display("FAIL down_tc: got %b want %b at %h", tcb, tc_exp[i], e); end
            end
            if (i == 1) up = 1'b1;
        end
        en = 1'b0;
        cyc(4);
    endtask

    task automatic test_saturate();
        int tcn, tcsn;
        up = 1'b1;
        do_load(8'hFF);
        tcn = 0; tcsn = 0;
        @(negedge clk);
        en = 1'b1;
        for (int i = 0; i < 9; i++) begin
            cyc(1);
            if (tc === 1'b1) tcn++;
            if (tc_s === 1'b1) tcsn++;
        end
        vectors++;
        if (l_s !== 10'h0FF) begin miscompares++; $display("FAIL sat_hold_top: got %h want 0ff", l_s); end
        vectors++;
        if (d_s !== disp(8'hFF)) begin miscompares++; $display("FAIL sat_disp_top: got %b want %b", d_s, disp(8'hFF)); end
        vectors++;
        if (tcsn != 1) begin miscompares++; $display("FAIL sat_tc_top: got %0d want 1", tcsn); end
        vectors++;
        if (l !== 10'h000) begin miscompares++; $display("FAIL wrap_top: got %h want 000", l); end
        vectors++;
        if (tcn != 1) begin miscompares++; $display("FAIL wrap_tc_top: got %0d want 1", tcn); end
        en = 1'b0;
        cyc(4);

        up = 1'b0;
        do_load(8'h00);
        tcn = 0; tcsn = 0;
        @(negedge clk);
        en = 1'b1;
        for (int i = 0; i < 9; i++) begin
            cyc(1);
            if (tc === 1'b1) tcn++;
            if (tc_s === 1'b1) tcsn++;
        end
        vectors++;
        if (l_s !== 10'h000) begin miscompares++; $display("FAIL sat_hold_zero: got %h want 000", l_s); end
        vectors++;
        if (tcsn != 1) begin miscompares++; $display("FAIL sat_tc_zero: got %0d want 1", tcsn); end
        vectors++;
        if (l !== 10'h0FF) begin miscompares++; $display("FAIL wrap_zero: got %h want 0ff", l); end
        en = 1'b0;
        up = 1'b1;
        cyc(4);
    endtask

    task automatic test_async_reset();
        do_load(8'h37);
        @(negedge clk);
        en = 1'b1;
        cyc(2);
        vectors++;
        if (l !== 10'h037) begin miscompares++; $display("FAIL pre_reset_value: got %h want 037", l); end
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        vectors++;
        if (l !== 10'h000) begin miscompares++; $display("FAIL async_rst_l: got %h want 000", l); end
        vectors++;
        if (d !== 14'b1000000_1000000) begin miscompares++; $display("FAIL async_rst_d: got %b want 10000001000000", d); end
        vectors++;
        if (tc !== 1'b0) begin miscompares++; $display("FAIL async_rst_tc: got %b want 0", tc); end
        vectors++;
        if (l_s !== 10'h000) begin miscompares++; $display("FAIL async_rst_sat_l: got %h want 000", l_s); end
        en = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        cyc(8);
        vectors++;
        if (l !== 10'h000) begin miscompares++; $display("FAIL post_reset_idle: got %h want 000", l); end
    endtask

    initial begin
        test_reset();
        test_load();
        test_step();
        test_count_up();
        test_count_down();
        test_saturate();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
